// File: rtl/key_loader_if.sv
// Serial key-provisioning bus: framed strobe inputs toward the loader and
// the committed key plus its status flags coming back.
interface key_loader_if #(
    parameter int KEY_WIDTH = 8
);
    logic                 key_start;
    logic                 key_valid;
    logic                 key_sdi;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_ready;
    logic                 key_load;
    logic                 key_err;
    logic                 key_locked;
    logic                 busy;

    modport master (
        output key_start, key_valid, key_sdi,
        input  key_out, key_ready, key_load, key_err, key_locked, busy
    );

    modport slave (
        input  key_start, key_valid, key_sdi,
        output key_out, key_ready, key_load, key_err, key_locked, busy
    );
endinterface

// File: rtl/key_loader.sv
// Receives a parity-protected serial key, commits it to the parallel key bus,
// and locks out permanently after MAX_FAIL consecutive parity failures.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for key_start
// S_SHIFT  | collecting KEY_WIDTH data bits, LSB first
// S_PAR    | waiting for the even-parity bit
// S_LOCKED | lockout; key forced to 0, only reset exits
module key_loader #(
    parameter int KEY_WIDTH = 8,
    parameter int MAX_FAIL  = 3
) (
    input  logic         clk,
    input  logic         rst,
    key_loader_if.slave  kif
);
    localparam int                CW       = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [CW-1:0]     LAST_BIT = CW'(KEY_WIDTH - 1);
    localparam logic [3:0]        FAIL_LIM = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PAR,
        S_LOCKED
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [KEY_WIDTH-1:0] r_shift;
    logic [3:0]           r_fail_cnt;
    logic [KEY_WIDTH-1:0] r_key_out;
    logic                 r_key_ready;
    logic                 r_key_load;
    logic                 r_key_err;
    logic                 r_key_locked;
    logic                 r_busy;

    logic                 w_par_bad;
    logic [3:0]           w_fail_next;

    assign w_par_bad   = (^r_shift) ^ kif.key_sdi;
    assign w_fail_next = r_fail_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_fail_cnt   <= '0;
            r_key_out    <= '0;
            r_key_ready  <= 1'b0;
            r_key_load   <= 1'b0;
            r_key_err    <= 1'b0;
            r_key_locked <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_key_load <= 1'b0;
            r_key_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // key_valid is deliberately ignored here, even alongside key_start
                    if (kif.key_start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (kif.key_start) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (kif.key_valid) begin
                        r_shift[r_cnt] <= kif.key_sdi;
                        if (r_cnt == LAST_BIT) begin
                            r_state <= S_PAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (kif.key_start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (kif.key_valid) begin
                        r_busy <= 1'b0;
                        if (!w_par_bad) begin
                            r_state     <= S_IDLE;
                            r_key_out   <= r_shift;
                            r_key_ready <= 1'b1;
                            r_key_load  <= 1'b1;
                            r_fail_cnt  <= '0;
                        end else begin
                            r_key_err  <= 1'b1;
                            r_fail_cnt <= w_fail_next;
                            if (w_fail_next == FAIL_LIM) begin
                                r_state      <= S_LOCKED;
                                r_key_locked <= 1'b1;
                                r_key_out    <= '0;
                                r_key_ready  <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_LOCKED: begin
                    r_key_locked <= 1'b1;
                    r_key_out    <= '0;
                    r_key_ready  <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kif.key_out    = r_key_out;
    assign kif.key_ready  = r_key_ready;
    assign kif.key_load   = r_key_load;
    assign kif.key_err    = r_key_err;
    assign kif.key_locked = r_key_locked;
    assign kif.busy       = r_busy;
endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good, gapped-bad, lockout, fail-counter,
// restart and mid-frame reset sequences with hand-computed expectations.
module tb_key_loader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   err_pulses;

    key_loader_if #(.KEY_WIDTH(8)) kif ();

    key_loader #(.KEY_WIDTH(8), .MAX_FAIL(3)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (kif.key_err) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        kif.key_start = 1'b1;
        tick();
        kif.key_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gaps);
        repeat (gaps) tick();
        kif.key_valid = 1'b1;
        kif.key_sdi   = b;
        tick();
        kif.key_valid = 1'b0;
        kif.key_sdi   = 1'b0;
    endtask

    // Returns sampled 1 time unit after the parity edge.
    task automatic frame(input logic [7:0] data, input logic par, input bit gapped);
        start();
        for (int i = 0; i < 8; i++) send_bit(data[i], gapped ? (i % 6) : 0);
        send_bit(par, gapped ? 3 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        err_pulses = 0;
        rst           = 1'b0;
        kif.key_start = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_sdi   = 1'b0;
        tick();
        tick();
        chk("rst_out",    kif.key_out,    0);
        chk("rst_ready",  kif.key_ready,  0);
        chk("rst_load",   kif.key_load,   0);
        chk("rst_err",    kif.key_err,    0);
        chk("rst_locked", kif.key_locked, 0);
        chk("rst_busy",   kif.busy,       0);
        rst = 1'b1;
        tick();

        // good frame 0xA5
        start();
        chk("good_busy_mid", kif.busy, 1);
        for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i), 0);
        send_bit(1'b0, 0);
        chk("good_out",   kif.key_out,   8'hA5);
        chk("good_ready", kif.key_ready, 1);
        chk("good_load",  kif.key_load,  1);
        chk("good_err",   kif.key_err,   0);
        chk("good_busy",  kif.busy,      0);
        tick();
        chk("good_load_clr", kif.key_load, 0);

        // gapped bad frame
        frame(8'hA5, 1'b1, 1'b1);
        chk("bad_err",   kif.key_err,   1);
        chk("bad_load",  kif.key_load,  0);
        chk("bad_out",   kif.key_out,   8'hA5);
        chk("bad_ready", kif.key_ready, 1);
        chk("bad_fail",  dut.r_fail_cnt, 1);
        tick();
        chk("bad_err_clr", kif.key_err, 0);

        // lockout after committed 0x3C
        frame(8'h3C, 1'b0, 1'b0);
        chk("lk_commit", kif.key_out, 8'h3C);
        chk("lk_fail0",  dut.r_fail_cnt, 0);
        frame(8'h3C, 1'b1, 1'b0);
        chk("lk_bad1_locked", kif.key_locked, 0);
        frame(8'h3C, 1'b1, 1'b0);
        chk("lk_bad2_locked", kif.key_locked, 0);
        chk("lk_bad2_out",    kif.key_out,    8'h3C);
        frame(8'h3C, 1'b1, 1'b0);
        chk("lk_locked", kif.key_locked, 1);
        chk("lk_out",    kif.key_out,    0);
        chk("lk_ready",  kif.key_ready,  0);
        chk("lk_err",    kif.key_err,    1);
        chk("lk_busy",   kif.busy,       0);
        frame(8'hA5, 1'b0, 1'b0);
        chk("lk_ign_locked", kif.key_locked, 1);
        chk("lk_ign_out",    kif.key_out,    0);
        chk("lk_ign_load",   kif.key_load,   0);
        chk("lk_ign_busy",   kif.busy,       0);
        do_reset();
        chk("lk_rst_locked", kif.key_locked, 0);

        // fail counter clears on good frame
        frame(8'h3C, 1'b1, 1'b0);
        frame(8'h0F, 1'b0, 1'b0);
        frame(8'h0F, 1'b1, 1'b0);
        frame(8'h0F, 1'b1, 1'b0);
        chk("fc_locked", kif.key_locked, 0);
        chk("fc_fail",   dut.r_fail_cnt, 2);
        chk("fc_out",    kif.key_out,    8'h0F);
        chk("fc_ready",  kif.key_ready,  1);

        // restart mid-frame
        tick();
        err_pulses = 0;
        start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        frame(8'h81, 1'b0, 1'b0);
        chk("rs_out",  kif.key_out,  8'h81);
        chk("rs_load", kif.key_load, 1);
        chk("rs_errs", err_pulses,   0);

        // start and valid together in IDLE: that bit is not shifted
        kif.key_start = 1'b1;
        kif.key_valid = 1'b1;
        kif.key_sdi   = 1'b1;
        tick();
        kif.key_start = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_sdi   = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        chk("sv_out",  kif.key_out,  8'h00);
        chk("sv_load", kif.key_load, 1);
        chk("sv_errs", err_pulses,   0);

        // reset mid-frame after committed 0x5A
        frame(8'h5A, 1'b0, 1'b0);
        chk("rm_commit", kif.key_out, 8'h5A);
        tick();
        start();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        chk("rm_busy_pre", kif.busy, 1);
        do_reset();
        chk("rm_out",    kif.key_out,    0);
        chk("rm_ready",  kif.key_ready,  0);
        chk("rm_busy",   kif.busy,       0);
        chk("rm_locked", kif.key_locked, 0);
        chk("rm_fail",   dut.r_fail_cnt, 0);
        frame(8'hC3, 1'b0, 1'b0);
        chk("rm_next_out",   kif.key_out,   8'hC3);
        chk("rm_next_ready", kif.key_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
